// File: rtl/sc_io_device.sv
// Board-side I/O endpoint: debounces slide switches into two CPU input ports and
// renders the low byte of two CPU output ports as decimal on six active-low digits.
module sc_io_device #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [9:0]  sw,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int PW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_STORE = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    logic [9:0]    r_sync1, r_sync2, r_samp, r_db;
    logic [PW-1:0] r_presc;
    logic          w_tick;

    state_t        r_state, w_next;
    logic [7:0]    r_snap;
    logic [11:0]   r_bcd;
    logic [3:0]    r_cnt;
    logic          r_sel;
    logic [11:0]   w_adj;
    logic [6:0]    w_seg_h, w_seg_t, w_seg_u;
    logic          w_unused_bits;

    assign w_tick        = (r_presc == PRESC_MAX);
    assign w_unused_bits = ^{out_port0[31:8], out_port1[31:8]};
    assign in_port0      = {27'd0, r_db[4:0]};
    assign in_port1      = {27'd0, r_db[9:5]};

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 10'd0;
            r_sync2 <= 10'd0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-period prescaler; tick fires on the terminal count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // A level is accepted only when two consecutive ticks see it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_samp <= 10'd0;
            r_db   <= 10'd0;
        end else if (w_tick) begin
            r_samp <= r_sync2;
            if (r_sync2 == r_samp) begin
                r_db <= r_sync2;
            end
        end
    end

    // Display FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Display FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: begin
                if (r_cnt == 4'd7) begin
                    w_next = S_STORE;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            S_STORE: w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    assign w_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

    // Double-dabble datapath: add-3 correction then shift the binary byte into BCD.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_snap <= 8'd0;
            r_bcd  <= 12'd0;
            r_cnt  <= 4'd0;
            r_sel  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_snap <= r_sel ? out_port1[7:0] : out_port0[7:0];
                    r_bcd  <= 12'd0;
                    r_cnt  <= 4'd0;
                end
                S_SHIFT: begin
                    {r_bcd, r_snap} <= {w_adj[10:0], r_snap, 1'b0};
                    r_cnt           <= r_cnt + 4'd1;
                end
                S_STORE: r_sel <= ~r_sel;
                default: r_sel <= 1'b0;
            endcase
        end
    end

    // Segment encoding with leading-zero blanking; units always shown.
    always_comb begin
        w_seg_h = SEG_BLANK;
        w_seg_t = SEG_BLANK;
        w_seg_u = seg7(r_bcd[3:0]);
        if (r_bcd[11:8] != 4'd0) begin
            w_seg_h = seg7(r_bcd[11:8]);
            w_seg_t = seg7(r_bcd[7:4]);
        end else if (r_bcd[7:4] != 4'd0) begin
            w_seg_t = seg7(r_bcd[7:4]);
        end else begin
            w_seg_t = SEG_BLANK;
        end
    end

    // All three digits of a port commit on the same edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else if (r_state == S_STORE) begin
            if (r_sel) begin
                hex5 <= w_seg_h;
                hex4 <= w_seg_t;
                hex3 <= w_seg_u;
            end else begin
                hex2 <= w_seg_h;
                hex1 <= w_seg_t;
                hex0 <= w_seg_u;
            end
        end
    end

endmodule
